// File: rtl/p2b_pkg.sv
// Shared constants, state encoding and packed-slice helper for the p2b converter.
// Optional bipolar decode is enabled with the P2B_BIPOLAR_EN macro.
package p2b_pkg;

   localparam int P2B_N_CH = 4;
   localparam int P2B_W    = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } p2b_state_e;

   // LSB position of channel ch inside a packed bus of w-bit channels.
   function automatic int ch_lsb(input int ch, input int w);
      return ch * w;
   endfunction

endpackage

// File: rtl/p2b_ones_counter.sv
// Per-channel ones counter; total includes the sample being counted this cycle.
// With P2B_BIPOLAR_EN defined it also produces the signed decode 2*ones - nc_lat.
module p2b_ones_counter
   import p2b_pkg::*;
#(
   parameter int W = P2B_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                inc,
`ifdef P2B_BIPOLAR_EN
   input  logic [W-1:0]        nc_lat,
   output logic signed [W:0]   bipolar,
`endif
   output logic [W-1:0]        total
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + W'(1);
      end
   end

   // ones never exceeds nc_lat, so this sum cannot wrap.
   assign total = count + W'(inc);

`ifdef P2B_BIPOLAR_EN
   // Modulo 2^(W+1) arithmetic is exact because the result lies in [-nc_lat, +nc_lat].
   assign bipolar = $signed({total, 1'b0} - {1'b0, nc_lat});
`endif

endmodule

// File: rtl/p2b_multi.sv
// Multi-channel stochastic-pulse-to-binary converter over a programmable window.
// Defining P2B_BIPOLAR_EN adds the signed b_bipolar output.
module p2b_multi
   import p2b_pkg::*;
#(
   parameter int N_CH = P2B_N_CH,
   parameter int W    = P2B_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [N_CH-1:0]        p_input,
   input  logic [W-1:0]           nc,
   output logic [N_CH*W-1:0]      b_output,
`ifdef P2B_BIPOLAR_EN
   output logic [N_CH*(W+1)-1:0]  b_bipolar,
`endif
   output logic                   out_valid,
   output logic                   busy,
   output p2b_state_e             state_dbg
);

   // Handshake: out_valid is a one-cycle strobe with no ready; b_output (and
   // b_bipolar) are valid on that cycle and hold until the next strobe.

   p2b_state_e       state, state_next;
   logic [W-1:0]     nc_lat;
   logic [W-1:0]     win_cnt;
   logic [W-1:0]     cnt_inc;
   logic [W-1:0]     eff_lat;
   logic             start, sample, last;
   logic [N_CH*W-1:0] b_next;
`ifdef P2B_BIPOLAR_EN
   logic [N_CH*(W+1)-1:0] bp_next;
`endif

   // The IDLE->RUN cycle is itself sample 1, so it compares against nc directly.
   always_comb begin
      start      = 1'b0;
      sample     = 1'b0;
      eff_lat    = nc_lat;
      cnt_inc    = win_cnt + W'(1);
      last       = 1'b0;
      state_next = state;
      start      = (state == IDLE) && enable && (nc != '0);
      sample     = enable && ((state == RUN) || start);
      if (start) begin
         eff_lat = nc;
      end
      last = sample && (cnt_inc == eff_lat);
      if (last) begin
         state_next = IDLE;
      end else if (start) begin
         state_next = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         nc_lat    <= '0;
         win_cnt   <= '0;
         b_output  <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_next;
         out_valid <= last;
         if (last) begin
            win_cnt  <= '0;
            nc_lat   <= '0;
            b_output <= b_next;
         end else if (sample) begin
            win_cnt <= cnt_inc;
            if (start) begin
               nc_lat <= nc;
            end
         end
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      p2b_ones_counter #(.W(W)) u_cnt (
         .clk     (clk),
         .rst     (rst),
         .clr     (last),
         .inc     (sample & p_input[i]),
`ifdef P2B_BIPOLAR_EN
         .nc_lat  (eff_lat),
         .bipolar (bp_next[ch_lsb(i, W+1) +: W+1]),
`endif
         .total   (b_next[ch_lsb(i, W) +: W])
      );
   end

`ifdef P2B_BIPOLAR_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         b_bipolar <= '0;
      end else if (last) begin
         b_bipolar <= bp_next;
      end
   end
`endif

   assign busy      = (nc_lat != '0);
   assign state_dbg = state;

endmodule

// File: tb/tb_p2b_multi.sv
// Bench for p2b_multi: table-driven windows plus hand-written corner sequences,
// with a scoreboard queue of expected b_output values.
module tb_p2b_multi;
   import p2b_pkg::*;

   localparam int N_CH = 4;
   localparam int W    = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic [N_CH-1:0]   p_input;
   logic [W-1:0]      nc;
   logic [N_CH*W-1:0] b_output;
   logic              out_valid;
   logic              busy;
   p2b_state_e        state_dbg;

   logic              enable4;
   logic [3:0]        p_input4;
   logic [3:0]        nc4;
   logic [15:0]       b_output4;
   logic              out_valid4;
   logic              busy4;
   p2b_state_e        state_dbg4;

`ifdef P2B_BIPOLAR_EN
   logic [N_CH*(W+1)-1:0] b_bipolar;
   logic [19:0]           b_bipolar4;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [N_CH*W-1:0] exp_q[$];
   int vcyc_q[$];

   typedef struct {
      logic [15:0]      nc;
      int               ncyc;
      logic [31:0]      en;
      logic [3:0][31:0] p;
      logic [63:0]      exp_b;
   } vec_t;
   vec_t vt[4];

   // Clock / reset block
   always #5 clk = ~clk;

   p2b_multi #(.N_CH(N_CH), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .p_input   (p_input),
      .nc        (nc),
      .b_output  (b_output),
`ifdef P2B_BIPOLAR_EN
      .b_bipolar (b_bipolar),
`endif
      .out_valid (out_valid),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   p2b_multi #(.N_CH(4), .W(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable4),
      .p_input   (p_input4),
      .nc        (nc4),
      .b_output  (b_output4),
`ifdef P2B_BIPOLAR_EN
      .b_bipolar (b_bipolar4),
`endif
      .out_valid (out_valid4),
      .busy      (busy4),
      .state_dbg (state_dbg4)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Driver: inputs change 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every out_valid strobe pops one expected result.
   always @(negedge clk) begin
      cyc++;
      if (out_valid === 1'b1) begin
         vcyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got b_output %h, expected no output", b_output);
         end else begin
            check("b_output", b_output, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [63:0] e;
      logic [3:0]  pr;
      logic        en_r;

      vt[0] = '{16'd8, 8, 32'hFF, {32'h04, 32'h55, 32'h00, 32'hFF}, 64'h0001_0004_0000_0008};
      vt[1] = '{16'd4, 6, 32'h35, {32'h00, 32'h00, 32'h0A, 32'h3F}, 64'h0000_0000_0000_0004};
      vt[2] = '{16'd5, 5, 32'h1F, {32'h00, 32'h1F, 32'h0A, 32'h13}, 64'h0000_0005_0002_0003};
      vt[3] = '{16'd3, 3, 32'h07, {32'h01, 32'h07, 32'h02, 32'h05}, 64'h0001_0003_0001_0002};

      rst = 1'b1; enable = 1'b0; p_input = '0; nc = '0;
      enable4 = 1'b0; p_input4 = '0; nc4 = '0;
      step();
      step();
      check("reset_b_output", b_output, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_state", state_dbg, IDLE);
      rst = 1'b0;
      step();

      // Table-driven windows
      for (int v = 0; v < 4; v++) begin
         exp_q.push_back(vt[v].exp_b);
         nc = vt[v].nc;
         for (int j = 0; j < vt[v].ncyc; j++) begin
            enable = vt[v].en[j];
            for (int i = 0; i < N_CH; i++) p_input[i] = vt[v].p[i][j];
            step();
            if (j < vt[v].ncyc - 1) check("busy_mid_window", busy, 1);
         end
         enable = 1'b0;
         step();
         check("window_result_seen", exp_q.size(), 0);
         check("busy_after_window", busy, 0);
`ifdef P2B_BIPOLAR_EN
         if (v == 0) check("b_bipolar", b_bipolar, {-17'sd6, 17'sd0, -17'sd8, 17'sd8});
`endif
      end

      // Back-to-back windows with nc changed mid-window
      enable = 1'b1; p_input = 4'b0001; nc = 16'd3;
      exp_q.push_back(64'h3);
      step();
      nc = 16'd5;
      step();
      step();
      exp_q.push_back(64'h5);
      for (int k = 0; k < 5; k++) step();
      enable = 1'b0;
      step();
      check("b2b_results_seen", exp_q.size(), 0);
      if (vcyc_q.size() >= 2) check("b2b_spacing", vcyc_q[$] - vcyc_q[$-1], 5);
      else check("b2b_valid_count", vcyc_q.size(), 2);

      // Reset mid-window discards the partial count
      enable = 1'b1; p_input = 4'hF; nc = 16'd10;
      for (int k = 0; k < 6; k++) step();
      check("busy_before_reset", busy, 1);
      rst = 1'b1; enable = 1'b0;
      step();
      check("midrst_b_output", b_output, 0);
      check("midrst_busy", busy, 0);
      check("midrst_out_valid", out_valid, 0);
      rst = 1'b0;
      step();
      check("midrst_no_valid", out_valid, 0);
      enable = 1'b1; nc = 16'd2;
      exp_q.push_back(64'h0002_0002_0002_0002);
      step();
      step();
      enable = 1'b0;
      step();
      check("post_reset_window_seen", exp_q.size(), 0);

      // nc = 0 never starts a window
      enable = 1'b1; nc = 16'd0;
      for (int k = 0; k < 5; k++) begin
         p_input = 4'($urandom_range(0, 15));
         step();
         check("nc0_busy", busy, 0);
         check("nc0_state", state_dbg, IDLE);
      end

      // nc = 1: each enabled cycle is a full window
      nc = 16'd1;
      for (int k = 0; k < 8; k++) begin
         en_r = (k != 3);
         pr = 4'($urandom_range(0, 15));
         enable = en_r; p_input = pr;
         if (en_r) begin
            e = '0;
            for (int i = 0; i < N_CH; i++) e[i*W +: W] = {15'b0, pr[i]};
            exp_q.push_back(e);
         end
         step();
      end
      enable = 1'b0;
      step();
      check("nc1_results_seen", exp_q.size(), 0);

      // W=4, nc=15 all ones: full-scale count without wrap
      enable4 = 1'b1; p_input4 = 4'hF; nc4 = 4'd15;
      for (int k = 0; k < 15; k++) begin
         step();
         if (k == 13) check("w4_no_early_valid", out_valid4, 0);
      end
      check("w4_out_valid", out_valid4, 1);
      check("w4_b_output", b_output4, 16'hFFFF);
      enable4 = 1'b0;
      step();
      check("w4_valid_one_cycle", out_valid4, 0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
